// File: rtl/dp_ram16k_fifo_ctrl_if.sv
// Streaming push/pop handshake bundle between a producer/consumer pair and the FIFO.
// master = producer/consumer side, slave = FIFO controller side.
interface dp_ram16k_fifo_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_data;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/dp_ram16k_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one DP_RAM16K (512 x 32) macro.
// The RAM's registered read output doubles as the FIFO head register.
module dp_ram16k_fifo_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DEPTH     = 512,
  parameter int DATA_W    = 32,
  parameter int AFULL_LVL = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  dp_ram16k_fifo_ctrl_if.slave stream,
  output logic [ADDR_W:0]      level,
  output logic                 almost_full,
  output logic                 ram_wen_n,
  output logic [ADDR_W-1:0]    ram_waddr,
  output logic [DATA_W-1:0]    ram_wdata,
  output logic [DATA_W-1:0]    ram_wenb,
  output logic                 ram_ren_n,
  output logic [ADDR_W-1:0]    ram_raddr,
  input  logic [DATA_W-1:0]    ram_rdata
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AFULL_LVL);

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   ram_cnt, ram_cnt_nxt;
  logic [ADDR_W:0]   level_nxt;
  logic              s1_valid, s1_valid_nxt;
  logic              push_ready_q, push_ready_nxt;
  logic              push_fire, pop_fire, rd_go;

  // flush masks every event so no RAM strobe escapes during the clear cycle
  assign push_fire = stream.push_valid & push_ready_q & ~flush;
  assign pop_fire  = s1_valid & stream.pop_ready & ~flush;
  assign rd_go     = (ram_cnt != '0) & (~s1_valid | stream.pop_ready) & ~flush;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    ram_cnt_nxt  = ram_cnt;
    s1_valid_nxt = s1_valid;

    if (flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      ram_cnt_nxt  = '0;
      s1_valid_nxt = 1'b0;
    end else begin
      if (push_fire) wr_ptr_nxt = wr_ptr + 1'b1;
      if (rd_go)     rd_ptr_nxt = rd_ptr + 1'b1;

      unique case ({push_fire, rd_go})
        2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
        2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
        default: ram_cnt_nxt = ram_cnt;
      endcase

      if (rd_go)         s1_valid_nxt = 1'b1;
      else if (pop_fire) s1_valid_nxt = 1'b0;
    end

    // push_ready is registered from the next-state level so it never sees pop_ready
    level_nxt      = ram_cnt_nxt + (ADDR_W+1)'(s1_valid_nxt);
    push_ready_nxt = (level_nxt != FULL_LVL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      s1_valid     <= 1'b0;
      push_ready_q <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      ram_cnt      <= ram_cnt_nxt;
      s1_valid     <= s1_valid_nxt;
      push_ready_q <= push_ready_nxt;
    end
  end

  assign level       = ram_cnt + (ADDR_W+1)'(s1_valid);
  assign almost_full = (level >= AF_LVL);

  assign stream.push_ready = push_ready_q;
  assign stream.pop_valid  = s1_valid;
  assign stream.pop_data   = ram_rdata;

  assign ram_wen_n = ~push_fire;
  assign ram_waddr = wr_ptr;
  assign ram_wdata = stream.push_data;
  assign ram_wenb  = '1;
  assign ram_ren_n = ~rd_go;
  assign ram_raddr = rd_ptr;

  // A read only targets words whose write edge has already passed.
  a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_fire && rd_go && (wr_ptr == rd_ptr)));

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level <= FULL_LVL);

endmodule

// File: tb/tb_dp_ram16k_fifo_ctrl.sv
// Self-checking bench: randomized traffic against a queue-based FWFT model plus a behavioural DP_RAM16K.
module tb_dp_ram16k_fifo_ctrl;
  localparam int ADDR_W    = 9;
  localparam int DEPTH     = 512;
  localparam int DATA_W    = 32;
  localparam int AFULL_LVL = 480;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [ADDR_W:0]   level;
  logic              almost_full;
  logic              ram_wen_n, ram_ren_n;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_wenb, ram_rdata;

  dp_ram16k_fifo_ctrl_if #(.DATA_W(DATA_W)) stream ();

  dp_ram16k_fifo_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .AFULL_LVL(AFULL_LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stream(stream),
    .level(level), .almost_full(almost_full),
    .ram_wen_n(ram_wen_n), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wenb(ram_wenb),
    .ram_ren_n(ram_ren_n), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural DP_RAM16K: synchronous bit-masked write, registered read.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!ram_wen_n) mem[ram_waddr] <= (mem[ram_waddr] & ~ram_wenb) | (ram_wdata & ram_wenb);
    if (!ram_ren_n) ram_rdata <= mem[ram_raddr];
  end

  // Reference model: words in flight, each visible at max(push+2, previous pop+1).
  typedef struct {
    logic [31:0] data;
    int          push_cyc;
    int          seq;
  } entry_t;

  entry_t q[$];
  int cyc = 0;
  int avail = 0;
  int wr_seq = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic            obs_push_ready, obs_pop_valid, obs_af, obs_wen_n, obs_ren_n;
  logic [31:0]     obs_pop_data;
  logic [ADDR_W:0] obs_level;
  logic [ADDR_W-1:0] obs_waddr;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic drive_cycle(input logic pv, input logic [31:0] pd, input logic pr, input logic fl);
    int     size, vis_at, rd_idx;
    logic   head_vis, exp_ready, push_fire, pop_fire;
    entry_t e;
    stream.push_valid = pv;
    stream.push_data  = pd;
    stream.pop_ready  = pr;
    flush             = fl;
    @(negedge clk);
    size      = q.size();
    exp_ready = (size != DEPTH);
    head_vis  = 1'b0;
    vis_at    = 0;
    if (size > 0) begin
      vis_at   = imax(avail, q[0].push_cyc + 2);
      head_vis = (cyc >= vis_at);
    end
    push_fire = pv && exp_ready && !fl;
    pop_fire  = head_vis && pr && !fl;
    rd_idx = -1;
    if (!fl) begin
      if (size > 0 && !head_vis && vis_at == cyc + 1) rd_idx = 0;
      else if (pop_fire && size > 1 && q[1].push_cyc + 2 <= cyc + 1) rd_idx = 1;
    end

    obs_push_ready = stream.push_ready;
    obs_pop_valid  = stream.pop_valid;
    obs_pop_data   = stream.pop_data;
    obs_level      = level;
    obs_af         = almost_full;
    obs_wen_n      = ram_wen_n;
    obs_ren_n      = ram_ren_n;
    obs_waddr      = ram_waddr;

    n_checks++;
    if (stream.push_ready !== exp_ready) begin
      n_fail++; $display("FAIL push_ready cyc=%0d got %b want %b", cyc, stream.push_ready, exp_ready);
    end
    n_checks++;
    if (stream.pop_valid !== head_vis) begin
      n_fail++; $display("FAIL pop_valid cyc=%0d got %b want %b", cyc, stream.pop_valid, head_vis);
    end
    n_checks++;
    if (level !== 10'(size)) begin
      n_fail++; $display("FAIL level cyc=%0d got %0d want %0d", cyc, level, size);
    end
    n_checks++;
    if (almost_full !== (size >= AFULL_LVL)) begin
      n_fail++; $display("FAIL almost_full cyc=%0d got %b want %b", cyc, almost_full, size >= AFULL_LVL);
    end
    n_checks++;
    if (ram_wen_n !== !push_fire) begin
      n_fail++; $display("FAIL ram_wen_n cyc=%0d got %b want %b", cyc, ram_wen_n, !push_fire);
    end
    n_checks++;
    if (ram_ren_n !== (rd_idx < 0)) begin
      n_fail++; $display("FAIL ram_ren_n cyc=%0d got %b want %b", cyc, ram_ren_n, rd_idx < 0);
    end
    n_checks++;
    if (ram_wenb !== '1) begin
      n_fail++; $display("FAIL ram_wenb cyc=%0d got %h want all ones", cyc, ram_wenb);
    end
    if (push_fire) begin
      n_checks++;
      if (ram_waddr !== 9'(wr_seq) || ram_wdata !== pd) begin
        n_fail++; $display("FAIL write cyc=%0d got addr %0d data %h want addr %0d data %h",
                           cyc, ram_waddr, ram_wdata, 9'(wr_seq), pd);
      end
    end
    if (rd_idx >= 0) begin
      n_checks++;
      if (ram_raddr !== 9'(q[rd_idx].seq)) begin
        n_fail++; $display("FAIL ram_raddr cyc=%0d got %0d want %0d", cyc, ram_raddr, 9'(q[rd_idx].seq));
      end
    end
    if (head_vis) begin
      n_checks++;
      if (stream.pop_data !== q[0].data) begin
        n_fail++; $display("FAIL pop_data cyc=%0d got %h want %h", cyc, stream.pop_data, q[0].data);
      end
    end

    @(posedge clk);
    if (fl) begin
      q.delete();
      wr_seq = 0;
      avail  = 0;
    end else begin
      if (pop_fire) begin
        e     = q.pop_front();
        avail = cyc + 1;
      end
      if (push_fire) begin
        q.push_back('{data: pd, push_cyc: cyc, seq: wr_seq});
        wr_seq++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain(input bit random_ready);
    for (int i = 0; i < 4000 && q.size() != 0; i++)
      drive_cycle(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_level !== '0) begin
      n_fail++; $display("FAIL drain_level got %0d want 0", obs_level);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    stream.push_valid = 1'b1;
    stream.push_data  = 32'hA5A5_5A5A;
    stream.pop_ready  = 1'b0;
    #12;
    n_checks++;
    if (ram_wen_n !== 1'b1 || stream.push_ready !== 1'b0 || stream.pop_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake got wen_n=%b push_ready=%b pop_valid=%b want 1 0 0",
                         ram_wen_n, stream.push_ready, stream.pop_valid);
    end
    n_checks++;
    if (level !== '0 || almost_full !== 1'b0 || ram_ren_n !== 1'b1 || ram_waddr !== '0 || ram_raddr !== '0) begin
      n_fail++; $display("FAIL reset_state got level=%0d af=%b ren_n=%b waddr=%0d raddr=%0d want 0 0 1 0 0",
                         level, almost_full, ram_ren_n, ram_waddr, ram_raddr);
    end
    #5 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stream.push_ready !== 1'b0 || ram_wen_n !== 1'b1) begin
      n_fail++; $display("FAIL release_pre_edge got push_ready=%b wen_n=%b want 0 1", stream.push_ready, ram_wen_n);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (stream.push_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_post_edge got push_ready=%b want 1", stream.push_ready);
    end
    stream.push_valid = 1'b0;
  endtask

  task automatic test_single_word();
    drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_pop_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_t1 got pop_valid=%b want 0", obs_pop_valid);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_pop_valid !== 1'b1 || obs_pop_data !== 32'hDEAD_BEEF || obs_level !== 10'd1) begin
      n_fail++; $display("FAIL single_t2 got valid=%b data=%h level=%0d want 1 deadbeef 1",
                         obs_pop_valid, obs_pop_data, obs_level);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_fill();
    int first_af = -1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
      if (first_af < 0 && obs_af === 1'b1) first_af = int'(obs_level);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (first_af != AFULL_LVL) begin
      n_fail++; $display("FAIL afull_threshold got first level %0d want %0d", first_af, AFULL_LVL);
    end
    n_checks++;
    if (obs_push_ready !== 1'b0 || obs_level !== 10'd512 || obs_af !== 1'b1) begin
      n_fail++; $display("FAIL full_state got ready=%b level=%0d af=%b want 0 512 1",
                         obs_push_ready, obs_level, obs_af);
    end
    drive_cycle(1'b1, $urandom, 1'b1, 1'b0);
    n_checks++;
    if (obs_push_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_with_pop got push_ready=%b want 0", obs_push_ready);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_push_ready !== 1'b1 || obs_level !== 10'd511) begin
      n_fail++; $display("FAIL after_pop got ready=%b level=%0d want 1 511", obs_push_ready, obs_level);
    end
    drain(1'b1);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 1100; i++) begin
      drive_cycle(1'b1, $urandom, 1'b1, 1'b0);
      if (i >= 2) begin
        n_checks++;
        if (obs_pop_valid !== 1'b1 || obs_level !== 10'd2) begin
          n_fail++; $display("FAIL stream_bubble i=%0d got valid=%b level=%0d want 1 2",
                             i, obs_pop_valid, obs_level);
        end
      end
    end
    drain(1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    first = $urandom;
    drive_cycle(1'b1, first, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0);
      n_checks++;
      if (obs_pop_valid !== 1'b1 || obs_pop_data !== first || obs_ren_n !== 1'b1) begin
        n_fail++; $display("FAIL backpressure i=%0d got valid=%b data=%h ren_n=%b want 1 %h 1",
                           i, obs_pop_valid, obs_pop_data, obs_ren_n, first);
      end
    end
    drain(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      logic pv, pr, fl;
      pv = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      pr = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 99) == 0);
      drive_cycle(pv, $urandom, pr, fl);
    end
    drain(1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 37; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_level !== 10'd37 || obs_pop_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup got level=%0d valid=%b want 37 1", obs_level, obs_pop_valid);
    end
    drive_cycle(1'b1, $urandom, 1'b1, 1'b1);
    n_checks++;
    if (obs_wen_n !== 1'b1 || obs_ren_n !== 1'b1) begin
      n_fail++; $display("FAIL flush_strobes got wen_n=%b ren_n=%b want 1 1", obs_wen_n, obs_ren_n);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (obs_level !== '0 || obs_pop_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear got level=%0d valid=%b want 0 0", obs_level, obs_pop_valid);
    end
    drive_cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    n_checks++;
    if (obs_wen_n !== 1'b0 || obs_waddr !== '0) begin
      n_fail++; $display("FAIL flush_repush got wen_n=%b waddr=%0d want 0 0", obs_wen_n, obs_waddr);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (obs_pop_valid !== 1'b1 || obs_pop_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL flush_readback got valid=%b data=%h want 1 12345678", obs_pop_valid, obs_pop_data);
    end
    drain(1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    stream.push_valid = 1'b1;
    stream.pop_ready  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (level !== '0 || stream.pop_valid !== 1'b0 || stream.push_ready !== 1'b0 ||
        ram_wen_n !== 1'b1 || ram_ren_n !== 1'b1) begin
      n_fail++; $display("FAIL async_reset got level=%0d valid=%b ready=%b wen_n=%b ren_n=%b want 0 0 0 1 1",
                         level, stream.pop_valid, stream.push_ready, ram_wen_n, ram_ren_n);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_streaming();
    test_backpressure();
    test_random();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
